// File: rtl/tx_sync_tr_gen.sv
//=============================================================================
// Module   : tx_sync_tr_gen
// Brief    : Transmit preamble generator. Emits a SYNC segment (PN word
//            repeated N times, optional per-repetition frequency hop)
//            followed by a TR segment (S0 word repeated TR_REP times),
//            one chip per chip strobe, MSB first.
// Revision : 1.0 - initial release
//=============================================================================
`default_nettype none

module tx_sync_tr_gen #(
  parameter int         TR_REP       = 4,
  parameter logic [4:0] DEF_SYNC_REP = 5'd16
) (
  input  logic        logic_clk_in,
  input  logic        logic_rst_in,
  input  logic        chip_en_in,
  input  logic [31:0] link_sync_pn,
  input  logic [3:0]  link_sync_hop_chan,
  input  logic        link_sync_pn_hop_en,
  input  logic [31:0] link_tr_s0,
  input  logic [5:0]  sync_rep_in,
  input  logic        tx_start_in,
  input  logic        tx_abort_in,
  output logic        chip_out,
  output logic        chip_valid_out,
  output logic [3:0]  hop_chan_out,
  output logic        sync_phase_out,
  output logic        tr_phase_out,
  output logic        tx_busy_out,
  output logic        tx_done_out,
  output logic [63:0] debug_signal
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_TR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Last repetition index of the TR segment.
  localparam logic [4:0] c_TR_LAST = 5'(TR_REP - 1);

  state_t      r_state;
  state_t      w_state_next;

  // Frame configuration captured at acceptance.
  logic [31:0] r_pn;
  logic [31:0] r_s0;
  logic [3:0]  r_hop_start;
  logic        r_hop_en;
  logic [4:0]  r_sync_last;   // N-1; a count of 0 (=32) wraps to 31 naturally

  logic [4:0]  r_chip_cnt;
  logic [4:0]  r_rep_cnt;
  logic [4:0]  w_chip_cnt_next;
  logic [4:0]  w_rep_cnt_next;

  logic        r_chip;
  logic        r_valid;
  logic [3:0]  r_hop_out;
  logic        r_sync_ph;
  logic        r_tr_ph;

  logic        w_latch;
  logic        w_emit;
  logic        w_emit_bit;
  logic [3:0]  w_emit_hop;
  logic        w_emit_sync;
  logic        w_emit_tr;
  logic        w_chip_last;
  logic [4:0]  w_sync_count;

  assign w_chip_last  = (r_chip_cnt == 5'd31);
  assign w_sync_count = sync_rep_in[5] ? sync_rep_in[4:0] : DEF_SYNC_REP;

  // Next-state, counter advance and chip selection; abort overrides everything.
  always_comb begin
    w_state_next    = r_state;
    w_chip_cnt_next = r_chip_cnt;
    w_rep_cnt_next  = r_rep_cnt;
    w_latch         = 1'b0;
    w_emit          = 1'b0;
    w_emit_bit      = 1'b0;
    w_emit_hop      = r_hop_out;
    w_emit_sync     = 1'b0;
    w_emit_tr       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (tx_start_in) begin
          w_latch         = 1'b1;
          w_state_next    = ST_SYNC;
          w_chip_cnt_next = 5'd0;
          w_rep_cnt_next  = 5'd0;
        end
      end
      ST_SYNC: begin
        if (chip_en_in) begin
          w_emit          = 1'b1;
          w_emit_bit      = r_pn[~r_chip_cnt];
          w_emit_hop      = r_hop_en ? (r_hop_start + r_rep_cnt[3:0]) : r_hop_start;
          w_emit_sync     = 1'b1;
          w_chip_cnt_next = r_chip_cnt + 5'd1;
          if (w_chip_last) begin
            if (r_rep_cnt == r_sync_last) begin
              w_state_next   = ST_TR;
              w_rep_cnt_next = 5'd0;
            end else begin
              w_rep_cnt_next = r_rep_cnt + 5'd1;
            end
          end
        end
      end
      ST_TR: begin
        if (chip_en_in) begin
          w_emit          = 1'b1;
          w_emit_bit      = r_s0[~r_chip_cnt];
          w_emit_tr       = 1'b1;
          w_chip_cnt_next = r_chip_cnt + 5'd1;
          if (w_chip_last) begin
            if (r_rep_cnt == c_TR_LAST) begin
              w_state_next   = ST_DONE;
              w_rep_cnt_next = 5'd0;
            end else begin
              w_rep_cnt_next = r_rep_cnt + 5'd1;
            end
          end
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    if (tx_abort_in) begin
      w_state_next    = ST_IDLE;
      w_chip_cnt_next = 5'd0;
      w_rep_cnt_next  = 5'd0;
      w_latch         = 1'b0;
      w_emit          = 1'b0;
    end
  end

  // State and counter registers.
  always_ff @(posedge logic_clk_in or negedge logic_rst_in) begin
    if (!logic_rst_in) begin
      r_state    <= ST_IDLE;
      r_chip_cnt <= 5'd0;
      r_rep_cnt  <= 5'd0;
    end else begin
      r_state    <= w_state_next;
      r_chip_cnt <= w_chip_cnt_next;
      r_rep_cnt  <= w_rep_cnt_next;
    end
  end

  // Configuration capture at frame acceptance, frozen for the whole frame.
  always_ff @(posedge logic_clk_in or negedge logic_rst_in) begin
    if (!logic_rst_in) begin
      r_pn        <= 32'd0;
      r_s0        <= 32'd0;
      r_hop_start <= 4'd0;
      r_hop_en    <= 1'b0;
      r_sync_last <= 5'd0;
    end else if (w_latch) begin
      r_pn        <= link_sync_pn;
      r_s0        <= link_tr_s0;
      r_hop_start <= link_sync_hop_chan;
      r_hop_en    <= link_sync_pn_hop_en;
      r_sync_last <= w_sync_count - 5'd1;
    end
  end

  // Registered chip outputs; phase flags follow the last emitted chip and drop outside a frame.
  always_ff @(posedge logic_clk_in or negedge logic_rst_in) begin
    if (!logic_rst_in) begin
      r_chip    <= 1'b0;
      r_valid   <= 1'b0;
      r_hop_out <= 4'd0;
      r_sync_ph <= 1'b0;
      r_tr_ph   <= 1'b0;
    end else begin
      r_valid <= w_emit;
      if (w_emit) begin
        r_chip    <= w_emit_bit;
        r_hop_out <= w_emit_hop;
        r_sync_ph <= w_emit_sync;
        r_tr_ph   <= w_emit_tr;
      end else if ((w_state_next == ST_IDLE) || (w_state_next == ST_DONE)) begin
        r_sync_ph <= 1'b0;
        r_tr_ph   <= 1'b0;
      end
    end
  end

  assign chip_out       = r_chip;
  assign chip_valid_out = r_valid;
  assign hop_chan_out   = r_hop_out;
  assign sync_phase_out = r_sync_ph;
  assign tr_phase_out   = r_tr_ph;
  assign tx_busy_out    = (r_state != ST_IDLE);
  assign tx_done_out    = (r_state == ST_DONE) && !tx_abort_in;
  assign debug_signal   = {r_state, r_rep_cnt, r_chip_cnt, r_hop_start, r_hop_en,
                           r_sync_last, 10'd0, r_pn};

endmodule

`default_nettype wire

// File: tb/tb_tx_sync_tr_gen.sv
//=============================================================================
// Module   : tb_tx_sync_tr_gen
// Brief    : Self-checking bench for tx_sync_tr_gen. Expected chip streams
//            are built from the frame rules (N x PN, TR_REP x S0, hop per
//            repetition) and compared chip by chip.
// Revision : 1.0 - initial release
//=============================================================================
`default_nettype none

module tb_tx_sync_tr_gen;

  logic        clk;
  logic        logic_rst_in;
  logic        chip_en_in;
  logic [31:0] link_sync_pn;
  logic [3:0]  link_sync_hop_chan;
  logic        link_sync_pn_hop_en;
  logic [31:0] link_tr_s0;
  logic [5:0]  sync_rep_in;
  logic        tx_start_in;
  logic        tx_abort_in;
  logic        chip_out;
  logic        chip_valid_out;
  logic [3:0]  hop_chan_out;
  logic        sync_phase_out;
  logic        tr_phase_out;
  logic        tx_busy_out;
  logic        tx_done_out;
  logic [63:0] debug_signal;

  int n_checks = 0;
  int n_pass   = 0;

  tx_sync_tr_gen dut (
    .logic_clk_in        (clk),
    .logic_rst_in        (logic_rst_in),
    .chip_en_in          (chip_en_in),
    .link_sync_pn        (link_sync_pn),
    .link_sync_hop_chan  (link_sync_hop_chan),
    .link_sync_pn_hop_en (link_sync_pn_hop_en),
    .link_tr_s0          (link_tr_s0),
    .sync_rep_in         (sync_rep_in),
    .tx_start_in         (tx_start_in),
    .tx_abort_in         (tx_abort_in),
    .chip_out            (chip_out),
    .chip_valid_out      (chip_valid_out),
    .hop_chan_out        (hop_chan_out),
    .sync_phase_out      (sync_phase_out),
    .tr_phase_out        (tr_phase_out),
    .tx_busy_out         (tx_busy_out),
    .tx_done_out         (tx_done_out),
    .debug_signal        (debug_signal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle-period observation: counts stray chips, done pulses and busy cycles.
  task automatic quiet(input int cycles, output int v, output int d, output int b);
    v = 0; d = 0; b = 0;
    for (int i = 0; i < cycles; i++) begin
      chip_en_in = ((i % 3) == 2);
      tick();
      if (chip_valid_out) v++;
      if (tx_done_out) d++;
      if (tx_busy_out) b++;
    end
    chip_en_in = 1'b0;
  endtask

  // One frame against the reference model.
  // mode: 0 normal, 1 abort on 40th chip, 2 reset on 100th chip,
  //       3 start pulsed during DONE, 4 start held for first 10 chips.
  task automatic run_frame(input logic [31:0] pn, input logic [31:0] s0,
                           input logic [3:0] ch, input logic hen,
                           input logic [5:0] rep6, input int period, input int mode);
    logic       exp_b[$];
    logic [3:0] exp_h[$];
    logic       exp_tr[$];
    int n, total, idx, spur, done_cnt, post, limit, v, d, b;
    logic en;
    bit stop;

    n = rep6[5] ? ((rep6[4:0] == 5'd0) ? 32 : int'(rep6[4:0])) : 16;
    for (int r = 0; r < n; r++)
      for (int k = 0; k < 32; k++) begin
        exp_b.push_back(pn[31-k]);
        exp_h.push_back(hen ? 4'((int'(ch) + r) % 16) : ch);
        exp_tr.push_back(1'b0);
      end
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 32; k++) begin
        exp_b.push_back(s0[31-k]);
        exp_h.push_back(hen ? 4'((int'(ch) + n - 1) % 16) : ch);
        exp_tr.push_back(1'b1);
      end
    total = exp_b.size();

    link_sync_pn        = pn;
    link_tr_s0          = s0;
    link_sync_hop_chan  = ch;
    link_sync_pn_hop_en = hen;
    sync_rep_in         = rep6;
    chip_en_in          = 1'b0;
    tx_start_in         = 1'b1;
    tick();
    tx_start_in = (mode == 4);
    // Configuration churn during the frame must not reach the output.
    link_sync_pn        = $urandom;
    link_tr_s0          = $urandom;
    link_sync_hop_chan  = 4'($urandom);
    link_sync_pn_hop_en = 1'($urandom);
    sync_rep_in         = 6'($urandom);

    n_checks++;
    if (tx_busy_out !== 1'b1) $display("FAIL busy_after_start: got %b want 1", tx_busy_out);
    else n_pass++;

    idx = 0; spur = 0; done_cnt = 0; post = 0; stop = 0;
    limit = total * period + 64;
    for (int cyc = 0; cyc < limit && !stop; cyc++) begin
      en = ((cyc % period) == (period - 1));
      chip_en_in = en;
      tick();
      if (mode == 3) tx_start_in = 1'b0;
      if (mode == 4 && idx >= 10) tx_start_in = 1'b0;
      if (chip_valid_out) begin
        if (!en || idx >= total) spur++;
        else begin
          n_checks++;
          if (chip_out !== exp_b[idx] || hop_chan_out !== exp_h[idx] ||
              sync_phase_out !== !exp_tr[idx] || tr_phase_out !== exp_tr[idx])
            $display("FAIL chip[%0d]: got bit=%b hop=%h sync=%b tr=%b want bit=%b hop=%h sync=%b tr=%b",
                     idx, chip_out, hop_chan_out, sync_phase_out, tr_phase_out,
                     exp_b[idx], exp_h[idx], !exp_tr[idx], exp_tr[idx]);
          else n_pass++;
          idx++;
          if (mode == 1 && idx == 40) begin
            chip_en_in  = 1'b0;
            tx_abort_in = 1'b1;
            tick();
            tx_abort_in = 1'b0;
            n_checks++;
            if (tx_busy_out !== 1'b0 || chip_valid_out !== 1'b0 || tx_done_out !== 1'b0)
              $display("FAIL abort_next_cycle: got busy=%b valid=%b done=%b want 0 0 0",
                       tx_busy_out, chip_valid_out, tx_done_out);
            else n_pass++;
            stop = 1;
          end
          if (mode == 2 && idx == 100) begin
            chip_en_in = 1'b0;
            #2 logic_rst_in = 1'b0;
            #1;
            n_checks++;
            if ({chip_out, chip_valid_out, hop_chan_out, sync_phase_out, tr_phase_out,
                 tx_busy_out, tx_done_out} !== 10'd0)
              $display("FAIL reset_mid_tr: got chip=%b valid=%b hop=%h sync=%b tr=%b busy=%b done=%b want all 0",
                       chip_out, chip_valid_out, hop_chan_out, sync_phase_out, tr_phase_out,
                       tx_busy_out, tx_done_out);
            else n_pass++;
            #2 logic_rst_in = 1'b1;
            stop = 1;
          end
        end
      end
      if (tx_done_out) begin
        done_cnt++;
        if (post == 0) post = 4;
        if (mode == 3) tx_start_in = 1'b1;
      end
      if (post > 0) begin
        post--;
        if (post == 0) stop = 1;
      end
    end
    chip_en_in  = 1'b0;
    tx_start_in = 1'b0;

    n_checks++;
    if (spur !== 0) $display("FAIL stray_valid: got %0d stray chips want 0", spur);
    else n_pass++;

    if (mode == 1 || mode == 2) begin
      quiet(80, v, d, b);
      n_checks++;
      if (v != 0 || d != 0 || b != 0)
        $display("FAIL after_terminate: got valid=%0d done=%0d busy=%0d want 0 0 0", v, d, b);
      else n_pass++;
    end else begin
      n_checks++;
      if (idx != total) $display("FAIL chip_count: got %0d want %0d", idx, total);
      else n_pass++;
      n_checks++;
      if (done_cnt != 1) $display("FAIL done_pulses: got %0d want 1", done_cnt);
      else n_pass++;
      n_checks++;
      if (tx_busy_out !== 1'b0) $display("FAIL busy_after_frame: got %b want 0", tx_busy_out);
      else n_pass++;
      if (mode == 3) begin
        quiet(40, v, d, b);
        n_checks++;
        if (v != 0 || d != 0 || b != 0)
          $display("FAIL start_in_done: got valid=%0d done=%0d busy=%0d want 0 0 0", v, d, b);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset();
    logic_rst_in = 1'b0;
    chip_en_in = 1'b0; tx_start_in = 1'b0; tx_abort_in = 1'b0;
    link_sync_pn = '0; link_tr_s0 = '0; link_sync_hop_chan = '0;
    link_sync_pn_hop_en = 1'b0; sync_rep_in = '0;
    tick(); tick();
    n_checks++;
    if ({chip_out, chip_valid_out, hop_chan_out, sync_phase_out, tr_phase_out,
         tx_busy_out, tx_done_out} !== 10'd0)
      $display("FAIL reset_state: got chip=%b valid=%b hop=%h sync=%b tr=%b busy=%b done=%b want all 0",
               chip_out, chip_valid_out, hop_chan_out, sync_phase_out, tr_phase_out,
               tx_busy_out, tx_done_out);
    else n_pass++;
    logic_rst_in = 1'b1;
    tick();
  endtask

  task automatic test_basic_frame();
    run_frame(32'hA5A5_0F0F, 32'h1234_5678, 4'h3, 1'b0, 6'h22, 8, 0);
  endtask

  task automatic test_hop();
    run_frame($urandom, $urandom, 4'hE, 1'b1, 6'h23, 8, 0);
  endtask

  task automatic test_rep32();
    run_frame($urandom, $urandom, 4'h5, 1'b1, 6'h20, 8, 0);
  endtask

  task automatic test_abort();
    run_frame($urandom, $urandom, 4'h1, 1'b1, 6'h22, 8, 1);
    run_frame($urandom, $urandom, 4'h7, 1'b0, 6'h22, 8, 0);
  endtask

  task automatic test_reset_mid_and_done_start();
    run_frame($urandom, $urandom, 4'h9, 1'b1, 6'h22, 8, 2);
    run_frame($urandom, $urandom, 4'hA, 1'b1, 6'h21, 4, 3);
  endtask

  task automatic test_start_abort();
    int v, d, b;
    tx_start_in = 1'b1;
    tx_abort_in = 1'b1;
    tick();
    tx_start_in = 1'b0;
    tx_abort_in = 1'b0;
    n_checks++;
    if (tx_busy_out !== 1'b0) $display("FAIL start_abort_busy: got %b want 0", tx_busy_out);
    else n_pass++;
    quiet(40, v, d, b);
    n_checks++;
    if (v != 0 || d != 0 || b != 0)
      $display("FAIL start_abort_quiet: got valid=%0d done=%0d busy=%0d want 0 0 0", v, d, b);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++)
      run_frame($urandom, $urandom, 4'($urandom), 1'($urandom), 6'($urandom),
                $urandom_range(1, 4), ((i % 2) == 1) ? 4 : 0);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_hop();
    test_rep32();
    test_abort();
    test_reset_mid_and_done_start();
    test_start_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
